// File: rtl/bulk_read_rr_arbiter_pkg.sv
// bulk_read_rr_arbiter_pkg: shared sizes, types and round-robin helper for the bulk arbiter
package bulk_arb_pkg;
  localparam int N_PORTS = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINE_SIZE = 4;
  localparam int MAX_OUTSTANDING = 4;
  localparam int ID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  typedef logic [ID_W-1:0] port_id_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_SIZE-1:0][DATA_W-1:0] line_t;
  typedef logic [LINE_SIZE-1:0][DATA_W/8-1:0] strb_t;
  function automatic port_id_t rr_next(port_id_t p);
    return (int'(p) == N_PORTS - 1) ? '0 : port_id_t'(p + 1'b1);
  endfunction
endpackage

// File: rtl/bulk_read_rr_arbiter_if.sv
// bulk_read_rr_arbiter_if: requester-side and memory-side bulk request/response bundle
interface bulk_read_rr_arbiter_if;
  import bulk_arb_pkg::*;
  logic [N_PORTS-1:0] s_req_valid, s_req_ready, s_req_write, s_lock, s_resp_valid;
  addr_t [N_PORTS-1:0] s_req_addr;
  line_t [N_PORTS-1:0] s_req_wdata;
  strb_t [N_PORTS-1:0] s_req_wstrb;
  line_t s_resp_rdata;
  logic m_req_valid, m_req_ready, m_req_write, m_resp_valid;
  addr_t m_req_addr;
  line_t m_req_wdata, m_resp_rdata;
  strb_t m_req_wstrb;
  modport slave (
    input  s_req_valid, s_req_write, s_lock, s_req_addr, s_req_wdata, s_req_wstrb, m_req_ready, m_resp_valid, m_resp_rdata,
    output s_req_ready, s_resp_valid, s_resp_rdata, m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb
  );
  modport master (
    output s_req_valid, s_req_write, s_lock, s_req_addr, s_req_wdata, s_req_wstrb, m_req_ready, m_resp_valid, m_resp_rdata,
    input  s_req_ready, s_resp_valid, s_resp_rdata, m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb
  );
endinterface

// File: rtl/bulk_read_rr_arbiter_id_fifo.sv
// bulk_arb_id_fifo: in-order FIFO of issuing port IDs for outstanding bulk requests
module bulk_arb_id_fifo
  import bulk_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  port_id_t din_i,
  output port_id_t head_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  port_id_t mem_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  // pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push_i);
      rd_q <= rd_q + PW'(pop_i);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  // storage is unreset: an entry is only read after it has been counted in
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  assign head_o = mem_q[rd_q];
  assign full_o = cnt_q == (PW+1)'(MAX_OUTSTANDING);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/bulk_read_rr_arbiter.sv
// bulk_read_rr_arbiter: round-robin N-port arbiter onto one bulk memory port; BULK_ARB_STATS_EN adds grant/stall counters
module bulk_read_rr_arbiter
  import bulk_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  bulk_read_rr_arbiter_if.slave bus,
  output logic err_orphan_o
`ifdef BULK_ARB_STATS_EN
  ,
  output logic [N_PORTS-1:0][31:0] grant_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);
  port_id_t rr_ptr_q, rr_ptr_d, hold_id_q, hold_id_d, lock_owner_q, lock_owner_d, gnt, idx, head;
  logic hold_valid_q, hold_valid_d, lock_valid_q, lock_valid_d, err_q, err_d;
  logic any_req, req_v, accept, pop, fifo_full, fifo_empty;
  logic [N_PORTS-1:0] elig;
  assign elig = lock_valid_q ? (bus.s_req_valid & (N_PORTS'(1) << lock_owner_q)) : bus.s_req_valid;
  // grant: a stalled grant is held, otherwise first eligible port scanning up from rr_ptr
  always_comb begin
    gnt = rr_ptr_q;
    idx = '0;
    any_req = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = port_id_t'((int'(rr_ptr_q) + k) % N_PORTS);
      if (elig[idx]) begin
        gnt = idx;
        any_req = 1'b1;
      end
    end
    if (hold_valid_q) begin
      gnt = hold_id_q;
      any_req = bus.s_req_valid[hold_id_q];
    end
  end
  assign req_v = rst_n && any_req && !fifo_full;
  assign accept = req_v && bus.m_req_ready;
  assign pop = rst_n && bus.m_resp_valid && !fifo_empty;
  assign bus.m_req_valid = req_v;
  assign bus.m_req_addr = req_v ? bus.s_req_addr[gnt] : '0;
  assign bus.m_req_write = req_v && bus.s_req_write[gnt];
  assign bus.m_req_wdata = req_v ? bus.s_req_wdata[gnt] : '0;
  assign bus.m_req_wstrb = req_v ? bus.s_req_wstrb[gnt] : '0;
  assign bus.s_req_ready = accept ? (N_PORTS'(1) << gnt) : '0;
  assign bus.s_resp_valid = pop ? (N_PORTS'(1) << head) : '0;
  assign bus.s_resp_rdata = bus.m_resp_rdata;
  assign err_orphan_o = err_q;
  // next state: pointer advances past each accepted port; lock drops when its owner lets go
  always_comb begin
    rr_ptr_d = accept ? rr_next(gnt) : rr_ptr_q;
    hold_valid_d = !accept && (hold_valid_q || (req_v && !bus.m_req_ready));
    hold_id_d = (!accept && req_v && !bus.m_req_ready) ? gnt : hold_id_q;
    lock_valid_d = accept ? bus.s_lock[gnt] : lock_valid_q && (bus.s_lock[lock_owner_q] || bus.s_req_valid[lock_owner_q]);
    lock_owner_d = accept ? gnt : lock_owner_q;
    err_d = err_q || (bus.m_resp_valid && fifo_empty);
  end
  // arbitration state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr_q <= '0;
      hold_valid_q <= 1'b0;
      hold_id_q <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      hold_valid_q <= hold_valid_d;
      hold_id_q <= hold_id_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      err_q <= err_d;
    end
  bulk_arb_id_fifo u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(accept), .pop_i(pop), .din_i(gnt),
    .head_o(head), .full_o(fifo_full), .empty_o(fifo_empty)
  );
`ifdef BULK_ARB_STATS_EN
  logic [N_PORTS-1:0][31:0] grant_cnt_q;
  logic [31:0] stall_cnt_q;
  // per-port accept counts and stall cycles (downstream back-pressure or ID FIFO full)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) grant_cnt_q[i] <= grant_cnt_q[i] + 32'(accept && gnt == port_id_t'(i));
      stall_cnt_q <= stall_cnt_q + 32'((req_v && !bus.m_req_ready) || (any_req && fifo_full));
    end
  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
